// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage PC and IF/ID register control with stall/flush handling.
// Tracks total and consecutive stall cycles and flags stalls that last too long.
module fetch_stall_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        Id_write,
  input  logic        ctrl_flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instr_in,
  output logic [15:0] pc_out,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        id_ex_bubble,
  output logic [1:0]  state,
  output logic [7:0]  stall_cnt,
  output logic        stall_timeout
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            r_state,   w_state_nxt;
  logic [PC_W-1:0]   r_pc,      w_pc_nxt;
  logic [PC_W-1:0]   r_instr,   w_instr_nxt;
  logic [PC_W-1:0]   r_ifpc,    w_ifpc_nxt;
  logic              r_valid,   w_valid_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [CNT_W-1:0]  r_consec,  w_consec_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic              w_stall;
  logic [PC_W-1:0]   w_pc_inc;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_consec_inc;

  assign w_stall      = !PCwrite || !Id_write;
  assign w_pc_inc     = r_pc + PC_W'(1);
  assign w_cnt_inc    = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
  assign w_consec_inc = (r_consec == CNT_MAX) ? CNT_MAX : r_consec + CNT_W'(1);

  // Bubble request to ID/EX does not wait for any register.
  assign id_ex_bubble = ctrl_flush || branch_taken;

  // Next-state: branch redirect beats stall, stall beats normal fetch.
  always_comb begin
    w_state_nxt   = RUN;
    w_pc_nxt      = w_pc_inc;
    w_instr_nxt   = instr_in;
    w_ifpc_nxt    = w_pc_inc;
    w_valid_nxt   = 1'b1;
    w_cnt_nxt     = r_cnt;
    w_consec_nxt  = '0;
    w_timeout_nxt = r_timeout;

    if (branch_taken) begin
      w_state_nxt = FLUSH;
      w_pc_nxt    = branch_target;
      w_instr_nxt = NOP_INSTR;
      w_ifpc_nxt  = '0;
      w_valid_nxt = 1'b0;
    end else if (w_stall) begin
      w_state_nxt  = STALL;
      w_cnt_nxt    = w_cnt_inc;
      w_consec_nxt = w_consec_inc;
      if (!PCwrite) begin
        w_pc_nxt = r_pc;
      end
      if (!Id_write) begin
        w_instr_nxt = r_instr;
        w_ifpc_nxt  = r_ifpc;
        w_valid_nxt = r_valid;
      end
      if (w_consec_inc == STALL_LIM) begin
        w_timeout_nxt = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_ifpc    <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_consec  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_ifpc    <= w_ifpc_nxt;
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_consec  <= w_consec_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign pc_out        = r_pc;
  assign if_id_instr   = r_instr;
  assign if_id_pc      = r_ifpc;
  assign if_id_valid   = r_valid;
  assign state         = r_state;
  assign stall_cnt     = r_cnt;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: fetch, stall, flush, timeout, saturation, wrap, reset.
module tb_fetch_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCwrite;
  logic        Id_write;
  logic        ctrl_flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr_in;
  logic [15:0] pc_out;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic [1:0]  state;
  logic [7:0]  stall_cnt;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  fetch_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .PCwrite       (PCwrite),
    .Id_write      (Id_write),
    .ctrl_flush    (ctrl_flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .id_ex_bubble  (id_ex_bubble),
    .state         (state),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    pc_out, 16'h0000);
    chk({tag, "_instr"}, if_id_instr, 16'h0000);
    chk({tag, "_ifpc"},  if_id_pc, 16'h0000);
    chk({tag, "_valid"}, 16'(if_id_valid), 16'd0);
    chk({tag, "_state"}, 16'(state), 16'd0);
    chk({tag, "_cnt"},   16'(stall_cnt), 16'd0);
    chk({tag, "_to"},    16'(stall_timeout), 16'd0);
  endtask

  initial begin
    rst = 1'b1; PCwrite = 1'b1; Id_write = 1'b1; ctrl_flush = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0000; instr_in = 16'h0000;
    step();
    chk_reset_vals("reset");

    // Three normal fetches
    rst = 1'b0; instr_in = 16'hA001;
    step(); chk("f1_pc", pc_out, 16'h0001); chk("f1_instr", if_id_instr, 16'hA001);
    instr_in = 16'hA002;
    step(); chk("f2_pc", pc_out, 16'h0002);
    instr_in = 16'hA003;
    step();
    chk("f3_pc", pc_out, 16'h0003); chk("f3_instr", if_id_instr, 16'hA003);
    chk("f3_ifpc", if_id_pc, 16'h0003); chk("f3_valid", 16'(if_id_valid), 16'd1);
    instr_in = 16'hB004; step();
    instr_in = 16'hB005; step();
    chk("f5_pc", pc_out, 16'h0005); chk("f5_ifpc", if_id_pc, 16'h0005);

    // Full stall with ctrl_flush for two cycles at pc=5
    PCwrite = 1'b0; Id_write = 1'b0; ctrl_flush = 1'b1; instr_in = 16'hC006;
    #1 chk("stall_bubble", 16'(id_ex_bubble), 16'd1);
    step();
    chk("s1_pc", pc_out, 16'h0005); chk("s1_state", 16'(state), 16'd1);
    chk("s1_cnt", 16'(stall_cnt), 16'd1); chk("s1_instr", if_id_instr, 16'hB005);
    step();
    chk("s2_pc", pc_out, 16'h0005); chk("s2_ifpc", if_id_pc, 16'h0005);
    chk("s2_cnt", 16'(stall_cnt), 16'd2); chk("s2_state", 16'(state), 16'd1);
    PCwrite = 1'b1; Id_write = 1'b1; ctrl_flush = 1'b0;
    #1 chk("rel_bubble", 16'(id_ex_bubble), 16'd0);
    step();
    chk("rel_pc", pc_out, 16'h0006); chk("rel_state", 16'(state), 16'd0);
    chk("rel_instr", if_id_instr, 16'hC006); chk("rel_ifpc", if_id_pc, 16'h0006);

    // ctrl_flush alone only bubbles
    ctrl_flush = 1'b1; instr_in = 16'hC007;
    #1 chk("cf_bubble", 16'(id_ex_bubble), 16'd1);
    step();
    chk("cf_pc", pc_out, 16'h0007); chk("cf_state", 16'(state), 16'd0);
    chk("cf_cnt", 16'(stall_cnt), 16'd2);

    // Branch taken beats concurrent stall
    ctrl_flush = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040; PCwrite = 1'b0;
    #1 chk("br_bubble", 16'(id_ex_bubble), 16'd1);
    step();
    chk("br_pc", pc_out, 16'h0040); chk("br_instr", if_id_instr, 16'h0000);
    chk("br_valid", 16'(if_id_valid), 16'd0); chk("br_ifpc", if_id_pc, 16'h0000);
    chk("br_state", 16'(state), 16'd2); chk("br_cnt", 16'(stall_cnt), 16'd2);
    branch_taken = 1'b0; PCwrite = 1'b1; instr_in = 16'hD040;
    step();
    chk("abr_state", 16'(state), 16'd0); chk("abr_pc", pc_out, 16'h0041);
    chk("abr_instr", if_id_instr, 16'hD040); chk("abr_valid", 16'(if_id_valid), 16'd1);

    // Consecutive-stall timeout at 15 (PC held, IF/ID keeps loading)
    PCwrite = 1'b0; instr_in = 16'hE000;
    for (int i = 1; i <= 14; i++) step();
    chk("to14", 16'(stall_timeout), 16'd0);
    step();
    chk("to15", 16'(stall_timeout), 16'd1);
    chk("to15_pc", pc_out, 16'h0041); chk("to15_ifpc", if_id_pc, 16'h0042);
    chk("to15_cnt", 16'(stall_cnt), 16'd17);
    PCwrite = 1'b1;
    step();
    chk("to_sticky", 16'(stall_timeout), 16'd1); chk("to_rel_pc", pc_out, 16'h0042);
    chk("to_rel_state", 16'(state), 16'd0);

    // Saturation: 300 total stall cycles
    PCwrite = 1'b0;
    for (int i = 1; i <= 237; i++) step();
    chk("sat254", 16'(stall_cnt), 16'd254);
    for (int i = 1; i <= 46; i++) step();
    chk("sat255", 16'(stall_cnt), 16'd255);
    chk("sat_to", 16'(stall_timeout), 16'd1);
    PCwrite = 1'b1;

    // PC wraps from FFFF
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step(); chk("wrap_pre", pc_out, 16'hFFFF);
    branch_taken = 1'b0; instr_in = 16'h1234;
    step();
    chk("wrap_pc", pc_out, 16'h0000); chk("wrap_ifpc", if_id_pc, 16'h0000);
    chk("wrap_valid", 16'(if_id_valid), 16'd1);

    // Reset clears counters and timeout
    rst = 1'b1; step();
    chk_reset_vals("rst2");
    rst = 1'b0; PCwrite = 1'b0;
    step(); step(); step();
    chk("pre_rst_cnt", 16'(stall_cnt), 16'd3); chk("pre_rst_state", 16'(state), 16'd1);

    // Reset mid-stall overrides branch and stall
    rst = 1'b1; branch_taken = 1'b1; branch_target = 16'h0077;
    #1 chk("rst_bubble", 16'(id_ex_bubble), 16'd1);
    step();
    chk_reset_vals("rst_stall");

    // Reset mid-flush
    rst = 1'b0; PCwrite = 1'b1;
    step(); chk("mf_state", 16'(state), 16'd2);
    rst = 1'b1;
    step();
    chk_reset_vals("rst_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
